// File: rtl/bus_fabric_pkg.sv
// Shared state type, status register offsets and address-map helpers
// for the CPU-side bus fabric.
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] RegFlags   = 2'd0;
   localparam logic [1:0] RegErrCnt  = 2'd1;
   localparam logic [1:0] RegFaultLo = 2'd2;
   localparam logic [1:0] RegFaultHi = 2'd3;

   localparam int MaxAw     = 32;
   localparam int MaxSlaves = 32;
   localparam int MaxMapW   = 2 * MaxAw * MaxSlaves;

   typedef logic [MaxMapW-1:0] map_t;
   typedef logic [MaxAw-1:0]   addr_t;

   // Entry idx sits at (n-1-idx)*2*aw so slave 0 lands in the MSBs.
   function automatic map_t add_address(
      input map_t  map,
      input int    aw,
      input int    n,
      input int    idx,
      input addr_t start_addr,
      input addr_t end_addr
   );
      int   base;
      map_t lo_mask;
      map_t field;
      base    = (n - 1 - idx) * 2 * aw;
      lo_mask = (map_t'(1) << aw) - map_t'(1);
      field   = ((map_t'(start_addr) & lo_mask) << aw)
              | (map_t'(end_addr) & lo_mask);
      return (map & ~(((lo_mask << aw) | lo_mask) << base))
           | (field << base);
   endfunction

   function automatic addr_t get_address_start(
      input map_t map,
      input int   aw,
      input int   n,
      input int   idx
   );
      int   base;
      map_t lo_mask;
      base    = (n - 1 - idx) * 2 * aw;
      lo_mask = (map_t'(1) << aw) - map_t'(1);
      return addr_t'((map >> (base + aw)) & lo_mask);
   endfunction

   function automatic addr_t get_address_end(
      input map_t map,
      input int   aw,
      input int   n,
      input int   idx
   );
      int   base;
      map_t lo_mask;
      base    = (n - 1 - idx) * 2 * aw;
      lo_mask = (map_t'(1) << aw) - map_t'(1);
      return addr_t'((map >> base) & lo_mask);
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority decoder: status window first, then the
// lowest-index slave window that contains the address.
module bus_addr_decode
   import bus_fabric_pkg::*;
#(
   parameter int NumSlaves         = 10,
   parameter int address_width     = 16,
   parameter logic [2*address_width*NumSlaves-1:0] AddrMap = '0,
   parameter int StatusBaseAddress = 'hA000,
   parameter int Address_Wording   = 4
) (
   input  logic [address_width-1:0] address,
   output logic [NumSlaves-1:0]     hit,
   output logic                     miss,
   output logic                     status_hit,
   output logic [1:0]               status_reg
);

   localparam map_t Map = map_t'(AddrMap);
   localparam logic [63:0] StLo = 64'(StatusBaseAddress);
   localparam logic [63:0] StHi = StLo + 64'(3 * Address_Wording);

   logic [NumSlaves-1:0] in_range;
   logic [63:0]          a64;
   logic [63:0]          offset;
   logic                 found;
   addr_t                addr_ext;

   assign addr_ext = addr_t'(address);
   assign a64      = 64'(address);
   assign offset   = a64 - StLo;

   for (genvar s = 0; s < NumSlaves; s++) begin : g_win
      localparam addr_t Lo =
         get_address_start(Map, address_width, NumSlaves, s);
      localparam addr_t Hi =
         get_address_end(Map, address_width, NumSlaves, s);
      assign in_range[s] = (addr_ext >= Lo) && (addr_ext <= Hi);
   end

   always_comb begin
      hit        = '0;
      found      = 1'b0;
      status_hit = (a64 >= StLo) && (a64 <= StHi);
      status_reg = 2'(offset / 64'(Address_Wording));
      for (int s = 0; s < NumSlaves; s++) begin
         if (!found && in_range[s]) begin
            hit[s] = 1'b1;
            found  = 1'b1;
         end
      end
      if (status_hit) hit = '0;
      miss = !status_hit && !found;
   end

endmodule

// File: rtl/cpu_bus_fabric.sv
// CPU-side interconnect: address decode, wait-state watchdog,
// registered read mux and the fabric's own error/status registers.
module cpu_bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int NumSlaves         = 10,
   parameter int address_width     = 16,
   parameter int data_width        = 8,
   parameter logic [2*address_width*NumSlaves-1:0] AddrMap = '0,
   parameter logic [NumSlaves-1:0] WaitMask = '0,
   parameter int TimeoutCycles     = 15,
   parameter int StatusBaseAddress = 'hA000,
   parameter int Address_Wording   = 4,
   parameter logic [data_width-1:0] DefaultData = 'hFF
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic [address_width-1:0]       cpu_address_i,
   input  logic                           cpu_req_i,
   input  logic                           cpu_we_i,
   input  logic [data_width-1:0]          cpu_wdata_i,
   output logic                           cpu_ready_o,
   output logic [data_width-1:0]          cpu_data_o,
   input  logic [NumSlaves*data_width-1:0] slave_data_i,
   input  logic [NumSlaves-1:0]           slave_ready_i,
   output logic [NumSlaves-1:0]           slave_sel_o
);

   state_t                   state;
   logic [NumSlaves-1:0]     dec_hit;
   logic                     dec_miss;
   logic                     dec_status;
   logic [1:0]               dec_reg;
   logic                     miss_q;
   logic                     status_q;
   logic                     we_q;
   logic                     wbit_q;
   logic [1:0]               reg_q;
   logic [address_width-1:0] addr_q;
   logic [address_width-1:0] fault_addr;
   logic [7:0]               cnt;
   logic [7:0]               err_cnt;
   logic                     timeout_flag;
   logic                     miss_flag;
   logic [data_width-1:0]    slave_rd;
   logic [data_width-1:0]    status_rd;
   logic [data_width-1:0]    resp_rd;
   logic                     slave_rdy;
   logic                     expired;
   logic                     err_miss;
   logic                     err_timeout;
   logic                     err_any;
   logic                     clr;
   logic                     unused_wdata;

   assign unused_wdata = ^cpu_wdata_i;

   bus_addr_decode #(
      .NumSlaves         (NumSlaves),
      .address_width     (address_width),
      .AddrMap           (AddrMap),
      .StatusBaseAddress (StatusBaseAddress),
      .Address_Wording   (Address_Wording)
   ) u_decode (
      .address    (cpu_address_i),
      .hit        (dec_hit),
      .miss       (dec_miss),
      .status_hit (dec_status),
      .status_reg (dec_reg)
   );

   always_comb begin
      slave_rd = '0;
      for (int s = 0; s < NumSlaves; s++) begin
         if (slave_sel_o[s]) begin
            slave_rd = slave_data_i[s*data_width +: data_width];
         end
      end
   end

   always_comb begin
      status_rd = '0;
      unique case (reg_q)
         RegFlags:   status_rd = data_width'({timeout_flag, miss_flag});
         RegErrCnt:  status_rd = data_width'(err_cnt);
         RegFaultLo: status_rd = data_width'(8'(fault_addr));
         RegFaultHi: status_rd = data_width'(8'(fault_addr >> 8));
      endcase
   end

   assign resp_rd = status_q ? status_rd
                  : miss_q   ? DefaultData
                  : slave_rd;

   assign slave_rdy   = |(slave_ready_i & slave_sel_o);
   assign expired     = (cnt == 8'(TimeoutCycles));
   assign err_miss    = (state == ST_RESP) && miss_q;
   assign err_timeout = (state == ST_WAIT) && !slave_rdy && expired;
   assign err_any     = err_miss || err_timeout;
   assign clr         = (state == ST_RESP) && status_q && we_q
                     && (reg_q == RegFlags) && wbit_q;

   // The ready cycle is spent in IDLE; requests seen during it are
   // ignored so consecutive transactions are at least 3 cycles apart.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state        <= ST_IDLE;
         cpu_ready_o  <= 1'b0;
         cpu_data_o   <= '0;
         slave_sel_o  <= '0;
         miss_q       <= 1'b0;
         status_q     <= 1'b0;
         we_q         <= 1'b0;
         wbit_q       <= 1'b0;
         reg_q        <= '0;
         addr_q       <= '0;
         cnt          <= '0;
         fault_addr   <= '0;
         err_cnt      <= '0;
         timeout_flag <= 1'b0;
         miss_flag    <= 1'b0;
      end else begin
         cpu_ready_o <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               slave_sel_o <= '0;
               if (cpu_req_i && !cpu_ready_o) begin
                  slave_sel_o <= dec_hit;
                  addr_q      <= cpu_address_i;
                  we_q        <= cpu_we_i;
                  wbit_q      <= cpu_wdata_i[0];
                  miss_q      <= dec_miss;
                  status_q    <= dec_status;
                  reg_q       <= dec_reg;
                  cnt         <= '0;
                  state <= (|(dec_hit & WaitMask)) ? ST_WAIT : ST_RESP;
               end
            end
            ST_WAIT: begin
               if (slave_rdy || expired) begin
                  cpu_ready_o <= 1'b1;
                  if (!we_q) begin
                     cpu_data_o <= slave_rdy ? slave_rd : DefaultData;
                  end
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_RESP: begin
               cpu_ready_o <= 1'b1;
               if (!we_q) cpu_data_o <= resp_rd;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A new error outranks a simultaneous clear.
         if (err_any) begin
            fault_addr   <= addr_q;
            timeout_flag <= err_timeout || (timeout_flag && !clr);
            miss_flag    <= err_miss || (miss_flag && !clr);
            if (clr) err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (clr) begin
            timeout_flag <= 1'b0;
            miss_flag    <= 1'b0;
            err_cnt      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed bench for cpu_bus_fabric: four-slave map with one wait slave,
// an overlapping pair and the status window at 0xA000.
module tb_cpu_bus_fabric;

   localparam logic [127:0] Map = {
      16'h0000, 16'h3000,
      16'h9000, 16'h900C,
      16'h9100, 16'h91FF,
      16'h9000, 16'h92FF
   };

   logic        clk;
   logic        reset_ni;
   logic [15:0] addr;
   logic        req;
   logic        we_r;
   logic [7:0]  wdata;
   logic        ready;
   logic [7:0]  data;
   logic [31:0] sdata;
   logic [3:0]  sready;
   logic [3:0]  sel;
   logic [7:0]  s1_data;

   int n_cmp;
   int n_bad;

   assign sdata = {8'h33, 8'h22, s1_data, 8'h5A};

   cpu_bus_fabric #(
      .NumSlaves         (4),
      .address_width     (16),
      .data_width        (8),
      .AddrMap           (Map),
      .WaitMask          (4'b0010),
      .TimeoutCycles     (4),
      .StatusBaseAddress ('hA000),
      .Address_Wording   (4),
      .DefaultData       (8'hFF)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_ni),
      .cpu_address_i (addr),
      .cpu_req_i     (req),
      .cpu_we_i      (we_r),
      .cpu_wdata_i   (wdata),
      .cpu_ready_o   (ready),
      .cpu_data_o    (data),
      .slave_data_i  (sdata),
      .slave_ready_i (sready),
      .slave_sel_o   (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One transaction; returns data in the ready cycle, edges from the
   // request edge to ready (-1 if it never came), and select at T+1.
   task automatic xfer(input logic [15:0] a, input logic w,
                       input logic [7:0] wd, output logic [7:0] d,
                       output int lat, output logic [3:0] s1);
      @(negedge clk);
      addr = a; we_r = w; wdata = wd; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      s1  = sel;
      lat = 0;
      while (ready !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      d = data;
      if (ready !== 1'b1) lat = -1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [7:0] d; int lat; logic [3:0] s;
      reset_ni = 1'b0; req = 1'b0; we_r = 1'b0; addr = '0;
      wdata = '0; sready = '0; s1_data = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_bad++;
         $display("FAIL reset_ready got %b want 0", ready); end
      n_cmp++; if (data !== 8'h00) begin n_bad++;
         $display("FAIL reset_data got %h want 00", data); end
      n_cmp++; if (sel !== 4'b0000) begin n_bad++;
         $display("FAIL reset_sel got %b want 0000", sel); end
      @(negedge clk); reset_ni = 1'b1;
      xfer(16'hA000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h00) begin n_bad++;
         $display("FAIL reset_flags got %h want 00", d); end
      n_cmp++; if (lat !== 1) begin n_bad++;
         $display("FAIL status_latency got %0d want 1", lat); end
      xfer(16'hA00C, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h00) begin n_bad++;
         $display("FAIL reset_fault_hi got %h want 00", d); end
   endtask

   task automatic test_nonwait();
      logic [7:0] d; int lat; logic [3:0] s;
      xfer(16'h0123, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (s !== 4'b0001) begin n_bad++;
         $display("FAIL nonwait_sel got %b want 0001", s); end
      n_cmp++; if (lat !== 1) begin n_bad++;
         $display("FAIL nonwait_latency got %0d want 1", lat); end
      n_cmp++; if (d !== 8'h5A) begin n_bad++;
         $display("FAIL nonwait_data got %h want 5a", d); end
      n_cmp++; if (sel !== 4'b0000) begin n_bad++;
         $display("FAIL nonwait_sel_idle got %b want 0000", sel); end
      xfer(16'h3000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h5A) begin n_bad++;
         $display("FAIL window_end got %h want 5a", d); end
      xfer(16'h3001, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'hFF || s !== 4'b0000) begin n_bad++;
         $display("FAIL past_end got %h/%b want ff/0000", d, s); end
      @(negedge clk); reset_ni = 1'b0;
      @(negedge clk); reset_ni = 1'b1;
   endtask

   task automatic test_wait();
      @(negedge clk);
      addr = 16'h9004; we_r = 1'b0; req = 1'b1; s1_data = 8'h33;
      @(posedge clk); #1;
      req = 1'b0;
      n_cmp++; if (sel !== 4'b0010) begin n_bad++;
         $display("FAIL wait_sel got %b want 0010", sel); end
      repeat (2) begin
         @(posedge clk); #1;
         n_cmp++; if (ready !== 1'b0) begin n_bad++;
            $display("FAIL wait_early_ready got %b want 0", ready); end
      end
      sready = 4'b0010;
      @(posedge clk); #1;
      sready = 4'b0000;
      n_cmp++; if (ready !== 1'b1 || data !== 8'h33) begin n_bad++;
         $display("FAIL wait_done got %b/%h want 1/33", ready, data); end
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b0 || sel !== 4'b0000) begin n_bad++;
         $display("FAIL wait_pulse got %b/%b want 0/0000", ready, sel); end
   endtask

   task automatic test_timeout();
      logic [7:0] d; int lat; logic [3:0] s;
      s1_data = 8'h77;
      xfer(16'h9004, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (lat !== 5) begin n_bad++;
         $display("FAIL timeout_latency got %0d want 5", lat); end
      n_cmp++; if (d !== 8'hFF) begin n_bad++;
         $display("FAIL timeout_data got %h want ff", d); end
      xfer(16'hA000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h02) begin n_bad++;
         $display("FAIL timeout_flags got %h want 02", d); end
      xfer(16'hA004, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h01) begin n_bad++;
         $display("FAIL timeout_count got %h want 01", d); end
      xfer(16'hA008, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h04) begin n_bad++;
         $display("FAIL timeout_fault_lo got %h want 04", d); end
      xfer(16'hA00C, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h90) begin n_bad++;
         $display("FAIL timeout_fault_hi got %h want 90", d); end
      xfer(16'hA000, 1'b1, 8'h01, d, lat, s);
      n_cmp++; if (d !== 8'h90 || lat !== 1) begin n_bad++;
         $display("FAIL write_keeps_data got %h/%0d want 90/1", d, lat); end
      xfer(16'hA000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h00) begin n_bad++;
         $display("FAIL clear_flags got %h want 00", d); end
   endtask

   task automatic test_miss_saturation();
      logic [7:0] d; int lat; logic [3:0] s;
      xfer(16'h7000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'hFF || lat !== 1) begin n_bad++;
         $display("FAIL miss_data got %h/%0d want ff/1", d, lat); end
      xfer(16'hA000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h01) begin n_bad++;
         $display("FAIL miss_flags got %h want 01", d); end
      xfer(16'hA00C, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h70) begin n_bad++;
         $display("FAIL miss_fault_hi got %h want 70", d); end
      xfer(16'hA010, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'hFF) begin n_bad++;
         $display("FAIL status_past_end got %h want ff", d); end
      for (int i = 0; i < 298; i++) begin
         xfer(16'h7000, 1'b0, 8'h00, d, lat, s);
      end
      xfer(16'hA004, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'hFF) begin n_bad++;
         $display("FAIL err_saturate got %h want ff", d); end
      xfer(16'hA000, 1'b1, 8'h01, d, lat, s);
      xfer(16'hA000, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h00) begin n_bad++;
         $display("FAIL miss_clear got %h want 00", d); end
      xfer(16'hA004, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h00) begin n_bad++;
         $display("FAIL count_clear got %h want 00", d); end
   endtask

   task automatic test_overlap();
      logic [7:0] d; int lat; logic [3:0] s;
      xfer(16'h9100, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (s !== 4'b0100 || d !== 8'h22) begin n_bad++;
         $display("FAIL overlap got %b/%h want 0100/22", s, d); end
      xfer(16'h9250, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (s !== 4'b1000 || d !== 8'h33) begin n_bad++;
         $display("FAIL slave3 got %b/%h want 1000/33", s, d); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] hist;
      @(negedge clk);
      addr = 16'h0123; we_r = 1'b0; req = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         hist[i] = ready;
      end
      req = 1'b0;
      n_cmp++; if (hist !== 9'b010010010) begin n_bad++;
         $display("FAIL back_to_back got %b want 010010010", hist); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_in_wait();
      logic [7:0] d; int lat; logic [3:0] s; int pulses;
      @(negedge clk);
      addr = 16'h9004; we_r = 1'b0; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk);
      @(negedge clk); reset_ni = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ready === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++;
         $display("FAIL reset_wait_pulse got %0d want 0", pulses); end
      n_cmp++; if (data !== 8'h00 || sel !== 4'b0000) begin n_bad++;
         $display("FAIL reset_wait_out got %h/%b want 00/0000", data, sel); end
      @(negedge clk); reset_ni = 1'b1;
      xfer(16'h0123, 1'b0, 8'h00, d, lat, s);
      n_cmp++; if (d !== 8'h5A || lat !== 1) begin n_bad++;
         $display("FAIL after_reset got %h/%0d want 5a/1", d, lat); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_nonwait();
      test_wait();
      test_timeout();
      test_miss_saturation();
      test_overlap();
      test_back_to_back();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
